// File: rtl/seq_gen.sv
`default_nettype none
// ============================================================================
// seq_gen : serial pattern generator, MSB-first with repeat count and idle gap
// Rev 1.0 : initial release
// ============================================================================
module seq_gen #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap_len,
    output logic             seq_out,
    output logic             valid_o,
    output logic             busy,
    output logic             done
);

    localparam int BC_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [GAP_W-1:0] gap_reg_q, gap_reg_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic             seq_out_q, seq_out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            shreg_q   <= '0;
            rep_cnt_q <= '0;
            gap_reg_q <= '0;
            gap_cnt_q <= '0;
            bit_cnt_q <= '0;
            seq_out_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            shreg_q   <= shreg_d;
            rep_cnt_q <= rep_cnt_d;
            gap_reg_q <= gap_reg_d;
            gap_cnt_q <= gap_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            seq_out_q <= seq_out_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Outputs are the registered image of the current state, one edge behind it.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        shreg_d   = shreg_q;
        rep_cnt_d = rep_cnt_q;
        gap_reg_d = gap_reg_q;
        gap_cnt_d = gap_cnt_q;
        bit_cnt_d = bit_cnt_q;
        seq_out_d = 1'b0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        if (abort) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (repeat_n != '0)) begin
                        pat_d     = pattern;
                        shreg_d   = pattern;
                        rep_cnt_d = repeat_n;
                        gap_reg_d = gap_len;
                        bit_cnt_d = '0;
                        gap_cnt_d = '0;
                        state_d   = SHIFT;
                    end
                end
                SHIFT: begin
                    seq_out_d = shreg_q[PAT_W-1];
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                    shreg_d   = {shreg_q[PAT_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + BC_W'(1);
                    if (bit_cnt_q == BC_W'(PAT_W - 1)) begin
                        bit_cnt_d = '0;
                        if (rep_cnt_q > CNT_W'(1)) begin
                            rep_cnt_d = rep_cnt_q - CNT_W'(1);
                            shreg_d   = pat_q;
                            state_d   = (gap_reg_q != '0) ? GAP : SHIFT;
                        end else begin
                            rep_cnt_d = '0;
                            state_d   = DONE;
                        end
                    end
                end
                GAP: begin
                    busy_d = 1'b1;
                    if (gap_cnt_q == gap_reg_q - GAP_W'(1)) begin
                        gap_cnt_d = '0;
                        state_d   = SHIFT;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign seq_out = seq_out_q;
    assign valid_o = valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_gen.sv
`default_nettype none
// ============================================================================
// tb_seq_gen : scoreboard bench for seq_gen, per-cycle {busy,valid,seq,done}
// Rev 1.0 : initial release
// ============================================================================
module tb_seq_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] pattern;
    logic [7:0] repeat_n;
    logic [3:0] gap_len;
    logic       seq_out;
    logic       valid_o;
    logic       busy;
    logic       done;

    int         n_tests;
    int         n_fail;
    logic [3:0] exp_q[$];

    seq_gen #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
        .clock    (clk),
        .reset    (rst),
        .start    (start),
        .abort    (abort),
        .pattern  (pattern),
        .repeat_n (repeat_n),
        .gap_len  (gap_len),
        .seq_out  (seq_out),
        .valid_o  (valid_o),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected trace from the edge that samples start: one quiet cycle, the
    // bits and gaps, the done pulse, then idle.
    function automatic void push_run(input logic [3:0] pat, input int reps, input int gap);
        exp_q.push_back(4'b0000);
        for (int r = 0; r < reps; r++) begin
            for (int b = 3; b >= 0; b--) exp_q.push_back({2'b11, pat[b], 1'b0});
            if (r < reps - 1)
                for (int g = 0; g < gap; g++) exp_q.push_back(4'b1000);
        end
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0000);
    endfunction

    task automatic launch(input logic [3:0] pat, input logic [7:0] reps, input logic [3:0] gap);
        @(negedge clk);
        pattern  = pat;
        repeat_n = reps;
        gap_len  = gap;
        start    = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        pattern = '0; repeat_n = '0; gap_len = '0;
        @(negedge clk);
        n_tests++;
        if ({busy, valid_o, seq_out, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset: got %b want 0000", {busy, valid_o, seq_out, done});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single;
        logic [3:0] e;
        int         cyc;
        launch(4'b1011, 8'd1, 4'd0);
        push_run(4'b1011, 1, 0);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front();
            n_tests++;
            if ({busy, valid_o, seq_out, done} !== e) begin
                n_fail++;
                $display("FAIL single cyc %0d: got %b want %b", cyc, {busy, valid_o, seq_out, done}, e);
            end
            cyc++;
        end
    endtask

    task automatic test_gap;
        logic [3:0] e;
        int         cyc;
        launch(4'b1011, 8'd3, 4'd2);
        push_run(4'b1011, 3, 2);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front();
            n_tests++;
            if ({busy, valid_o, seq_out, done} !== e) begin
                n_fail++;
                $display("FAIL gap cyc %0d: got %b want %b", cyc, {busy, valid_o, seq_out, done}, e);
            end
            cyc++;
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] e;
        int         cyc;
        launch(4'b1101, 8'd2, 4'd0);
        push_run(4'b1101, 2, 0);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 3) pattern = 4'b0000;
            e = exp_q.pop_front();
            n_tests++;
            if ({busy, valid_o, seq_out, done} !== e) begin
                n_fail++;
                $display("FAIL b2b cyc %0d: got %b want %b", cyc, {busy, valid_o, seq_out, done}, e);
            end
            cyc++;
        end
    endtask

    task automatic test_zero_repeat;
        logic [3:0] e;
        int         cyc;
        launch(4'b1111, 8'd0, 4'd1);
        for (int i = 0; i < 4; i++) exp_q.push_back(4'b0000);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            e = exp_q.pop_front();
            n_tests++;
            if ({busy, valid_o, seq_out, done} !== e) begin
                n_fail++;
                $display("FAIL zero_rep cyc %0d: got %b want %b", cyc, {busy, valid_o, seq_out, done}, e);
            end
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_abort;
        logic [3:0] e;
        int         cyc;
        launch(4'b1011, 8'd4, 4'd1);
        push_run(4'b1011, 4, 1);
        while (exp_q.size() > 8) void'(exp_q.pop_back());
        for (int i = 0; i < 5; i++) exp_q.push_back(4'b0000);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front();
            n_tests++;
            if ({busy, valid_o, seq_out, done} !== e) begin
                n_fail++;
                $display("FAIL abort cyc %0d: got %b want %b", cyc, {busy, valid_o, seq_out, done}, e);
            end
            abort = (cyc == 7);
            cyc++;
        end
        launch(4'b0110, 8'd2, 4'd1);
        push_run(4'b0110, 2, 1);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front();
            n_tests++;
            if ({busy, valid_o, seq_out, done} !== e) begin
                n_fail++;
                $display("FAIL post_abort cyc %0d: got %b want %b", cyc, {busy, valid_o, seq_out, done}, e);
            end
            cyc++;
        end
    endtask

    task automatic test_async_reset;
        logic [3:0] e;
        int         cyc;
        launch(4'b1011, 8'd3, 4'd3);
        push_run(4'b1011, 3, 3);
        for (cyc = 0; cyc <= 6; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front();
            n_tests++;
            if ({busy, valid_o, seq_out, done} !== e) begin
                n_fail++;
                $display("FAIL pre_rst cyc %0d: got %b want %b", cyc, {busy, valid_o, seq_out, done}, e);
            end
        end
        exp_q.delete();
        #1;
        rst      = 1'b1;
        start    = 1'b1;
        pattern  = 4'b1101;
        repeat_n = 8'd1;
        gap_len  = 4'd0;
        #1;
        n_tests++;
        if ({busy, valid_o, seq_out, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_rst: got %b want 0000", {busy, valid_o, seq_out, done});
        end
        @(negedge clk);
        rst = 1'b0;
        push_run(4'b1101, 1, 0);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front();
            n_tests++;
            if ({busy, valid_o, seq_out, done} !== e) begin
                n_fail++;
                $display("FAIL post_rst cyc %0d: got %b want %b", cyc, {busy, valid_o, seq_out, done}, e);
            end
            cyc++;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single();
        test_gap();
        test_back_to_back();
        test_zero_repeat();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
